// File: rtl/wb_commit_queue.sv
// Writeback commit queue: accepts up to LANES results per cycle, retires up to
// WPORTS oldest entries per cycle onto the RF write ports, and forwards the youngest pending value.
module wb_fwd_port #(
  parameter int DEPTH      = 4,
  parameter int RF_ADDR_WD = 5,
  parameter int RF_DATA_WD = 64
) (
  input  logic [RF_ADDR_WD-1:0]                  raddr,
  input  logic [DEPTH-1:0]                       q_we,
  input  logic [DEPTH-1:0][RF_ADDR_WD-1:0]       q_rd,
  input  logic [DEPTH-1:0][RF_DATA_WD-1:0]       q_data,
  input  logic [$clog2(DEPTH)-1:0]               head,
  input  logic [$clog2(DEPTH):0]                 count,
  output logic                                   hit,
  output logic [RF_DATA_WD-1:0]                  data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < count && q_we[idx] && q_rd[idx] == raddr && raddr != '0) begin
        hit  = 1'b1;
        data = q_data[idx];
      end
    end
  end
endmodule

module wb_commit_queue #(
  parameter int LANES      = 2,
  parameter int DEPTH      = 4,
  parameter int WPORTS     = 1,
  parameter int FWD_PORTS  = 2,
  parameter int RF_ADDR_WD = 5,
  parameter int RF_DATA_WD = 64,
  parameter int PC_WD      = 64
) (
  input  logic                                             clk,
  input  logic                                             reset,
  output logic                                             ws_allowin,
  input  logic                                             ms_to_ws_valid,
  input  logic [LANES*(2+RF_ADDR_WD+RF_DATA_WD+PC_WD)-1:0] ms_to_ws_bus,
  output logic [WPORTS-1:0]                                rf_we,
  output logic [WPORTS*RF_ADDR_WD-1:0]                     rf_waddr,
  output logic [WPORTS*RF_DATA_WD-1:0]                     rf_wdata,
  input  logic [FWD_PORTS*RF_ADDR_WD-1:0]                  fwd_raddr,
  output logic [FWD_PORTS-1:0]                             fwd_hit,
  output logic [FWD_PORTS*RF_DATA_WD-1:0]                  fwd_data,
  output logic [WPORTS-1:0]                                commit_valid,
  output logic [WPORTS*PC_WD-1:0]                          commit_pc,
  output logic [$clog2(DEPTH):0]                           occupancy
);
  localparam int LW = 2 + RF_ADDR_WD + RF_DATA_WD + PC_WD;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic                  we;
    logic [RF_ADDR_WD-1:0] rd;
    logic [RF_DATA_WD-1:0] data;
    logic [PC_WD-1:0]      pc;
  } entry_t;

  logic [DEPTH-1:0]                 q_we;
  logic [DEPTH-1:0][RF_ADDR_WD-1:0] q_rd;
  logic [DEPTH-1:0][RF_DATA_WD-1:0] q_data;
  logic [DEPTH-1:0][PC_WD-1:0]      q_pc;
  logic [PW-1:0]                    head, tail;
  logic [CW-1:0]                    count, n_in, n_out;
  logic [LANES-1:0]                 lane_v;
  entry_t                           lane_e [LANES];
  logic [LANES-1:0][PW-1:0]         wr_idx;
  logic                             enq;
  logic [WPORTS-1:0]                raw_we;
  logic [WPORTS-1:0][PW-1:0]        rd_idx;

  // Valid lanes pack into consecutive tail slots; skipped lanes leave no hole.
  always_comb begin
    n_in = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_v[l] = ms_to_ws_bus[l*LW + LW-1];
      lane_e[l] = ms_to_ws_bus[l*LW +: LW-1];
      wr_idx[l] = tail + n_in[PW-1:0];
      if (lane_v[l]) n_in = n_in + CW'(1);
    end
  end

  assign ws_allowin = (DEPTH - int'(count)) >= LANES;
  assign enq        = ms_to_ws_valid && ws_allowin;
  assign n_out      = (count < CW'(WPORTS)) ? count : CW'(WPORTS);
  assign occupancy  = count;

  // Younger port wins a same-rd conflict, so older ports are squashed.
  always_comb begin
    rf_we        = '0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    commit_pc    = '0;
    commit_valid = '0;
    raw_we       = '0;
    for (int i = 0; i < WPORTS; i++) begin
      rd_idx[i]       = head + PW'(i);
      commit_valid[i] = CW'(i) < count;
      raw_we[i]       = commit_valid[i] && q_we[rd_idx[i]] && q_rd[rd_idx[i]] != '0;
      if (commit_valid[i]) begin
        rf_waddr[i*RF_ADDR_WD +: RF_ADDR_WD] = q_rd[rd_idx[i]];
        rf_wdata[i*RF_DATA_WD +: RF_DATA_WD] = q_data[rd_idx[i]];
        commit_pc[i*PC_WD +: PC_WD]          = q_pc[rd_idx[i]];
      end
    end
    for (int i = 0; i < WPORTS; i++) begin
      rf_we[i] = raw_we[i];
      for (int j = i + 1; j < WPORTS; j++)
        if (raw_we[j] && q_rd[rd_idx[j]] == q_rd[rd_idx[i]]) rf_we[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + n_out[PW-1:0];
      tail  <= enq ? tail + n_in[PW-1:0] : tail;
      count <= count + (enq ? n_in : '0) - n_out;
      for (int l = 0; l < LANES; l++) begin
        if (enq && lane_v[l]) begin
          q_we[wr_idx[l]]   <= lane_e[l].we;
          q_rd[wr_idx[l]]   <= lane_e[l].rd;
          q_data[wr_idx[l]] <= lane_e[l].data;
          q_pc[wr_idx[l]]   <= lane_e[l].pc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (count <= CW'(DEPTH));
  end

  for (genvar p = 0; p < FWD_PORTS; p++) begin : g_fwd
    wb_fwd_port #(
      .DEPTH(DEPTH), .RF_ADDR_WD(RF_ADDR_WD), .RF_DATA_WD(RF_DATA_WD)
    ) u_fwd (
      .raddr (fwd_raddr[p*RF_ADDR_WD +: RF_ADDR_WD]),
      .q_we  (q_we),
      .q_rd  (q_rd),
      .q_data(q_data),
      .head  (head),
      .count (count),
      .hit   (fwd_hit[p]),
      .data  (fwd_data[p*RF_DATA_WD +: RF_DATA_WD])
    );
  end
endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue: one WPORTS=1 instance and one WPORTS=2 instance.
module tb_wb_commit_queue;
  localparam int LW = 135;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            valid;
  logic [2*LW-1:0] bus;
  logic [9:0]      fwd_raddr;
  logic            allowin;
  logic [0:0]      rf_we, commit_valid;
  logic [4:0]      rf_waddr;
  logic [63:0]     rf_wdata, commit_pc;
  logic [1:0]      fwd_hit;
  logic [127:0]    fwd_data;
  logic [2:0]      occupancy;

  logic            b_valid;
  logic [2*LW-1:0] b_bus;
  logic [9:0]      b_fwd_raddr;
  logic            b_allowin;
  logic [1:0]      b_rf_we, b_commit_valid, b_fwd_hit;
  logic [9:0]      b_rf_waddr;
  logic [127:0]    b_rf_wdata, b_commit_pc, b_fwd_data;
  logic [2:0]      b_occupancy;

  wb_commit_queue #(.WPORTS(1)) u_dut (
    .clk(clk), .reset(reset), .ws_allowin(allowin), .ms_to_ws_valid(valid),
    .ms_to_ws_bus(bus), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .occupancy(occupancy)
  );

  wb_commit_queue #(.WPORTS(2)) u_dut2 (
    .clk(clk), .reset(reset), .ws_allowin(b_allowin), .ms_to_ws_valid(b_valid),
    .ms_to_ws_bus(b_bus), .rf_we(b_rf_we), .rf_waddr(b_rf_waddr), .rf_wdata(b_rf_wdata),
    .fwd_raddr(b_fwd_raddr), .fwd_hit(b_fwd_hit), .fwd_data(b_fwd_data),
    .commit_valid(b_commit_valid), .commit_pc(b_commit_pc), .occupancy(b_occupancy)
  );

  int total = 0, passed = 0, fails = 0;

  function automatic logic [LW-1:0] ln(input logic v, input logic we, input logic [4:0] rd,
                                       input logic [63:0] d, input logic [63:0] pc);
    return {v, we, rd, d, pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, held, grp;
    logic acc;
    reset = 1'b1; valid = 1'b0; bus = '0; fwd_raddr = {5'd5, 5'd5};
    b_valid = 1'b0; b_bus = '0; b_fwd_raddr = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    // 1: idle after reset
    chk("idle_occ", 64'(occupancy), 0);
    chk("idle_allowin", 64'(allowin), 1);
    chk("idle_rf_we", 64'(rf_we), 0);
    chk("idle_fwd_hit", 64'(fwd_hit), 0);
    // 1: build count=3, then reset discards it
    valid = 1'b1;
    bus = {ln(1, 1, 5'd1, 64'h11, 64'h0), ln(1, 1, 5'd2, 64'h22, 64'h0)};
    tick();
    chk("fill_occ2", 64'(occupancy), 2);
    bus = {ln(1, 1, 5'd3, 64'h33, 64'h0), ln(1, 1, 5'd4, 64'h44, 64'h0)};
    tick();
    chk("fill_occ3", 64'(occupancy), 3);
    valid = 1'b0; reset = 1'b1;
    tick();
    chk("rst_occ", 64'(occupancy), 0);
    chk("rst_rf_we", 64'(rf_we), 0);
    chk("rst_cv", 64'(commit_valid), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_occ", 64'(occupancy), 0);

    // 2: one group, in-order retirement
    valid = 1'b1;
    bus = {ln(1, 1, 5'd6, 64'hBB, 64'h80000004), ln(1, 1, 5'd5, 64'hAA, 64'h80000000)};
    tick();
    valid = 1'b0;
    chk("g_occ2", 64'(occupancy), 2);
    chk("g_we0", 64'(rf_we), 1);
    chk("g_addr0", 64'(rf_waddr), 5);
    chk("g_data0", rf_wdata, 64'hAA);
    chk("g_pc0", commit_pc, 64'h80000000);
    tick();
    chk("g_occ1", 64'(occupancy), 1);
    chk("g_addr1", 64'(rf_waddr), 6);
    chk("g_data1", rf_wdata, 64'hBB);
    chk("g_pc1", commit_pc, 64'h80000004);
    tick();
    chk("g_occ0", 64'(occupancy), 0);
    chk("g_cv_empty", 64'(commit_valid), 0);

    // 3: three back-to-back groups, wrap-around, upstream holds on !allowin
    k = 0; held = 0; grp = 0;
    for (int it = 0; it < 12; it++) begin
      if (rf_we[0]) begin
        chk("bb_addr", 64'(rf_waddr), 64'(10 + k));
        chk("bb_data", rf_wdata, 64'h100 + 64'(k));
        k++;
      end
      acc = 1'b0;
      if (grp < 3) begin
        valid = 1'b1;
        bus = {ln(1, 1, 5'(11 + 2*grp), 64'h101 + 64'(2*grp), 64'h0),
               ln(1, 1, 5'(10 + 2*grp), 64'h100 + 64'(2*grp), 64'h0)};
        if (!allowin) held++;
        acc = allowin;
      end else begin
        valid = 1'b0;
      end
      tick();
      if (acc) grp++;
    end
    chk("bb_writes", 64'(k), 6);
    chk("bb_held", 64'(held), 1);
    chk("bb_occ", 64'(occupancy), 0);

    // 4: forwarding picks youngest, excludes incoming, clears after retire
    valid = 1'b1;
    bus = {ln(1, 1, 5'd7, 64'd2, 64'h0), ln(1, 1, 5'd7, 64'd1, 64'h0)};
    fwd_raddr = {5'd5, 5'd7};
    #1;
    chk("fwd_incoming", 64'(fwd_hit), 0);
    tick();
    valid = 1'b0;
    chk("fwd_hit_both", 64'(fwd_hit), 2'b01);
    chk("fwd_data_both", fwd_data[63:0], 64'd2);
    chk("fwd_miss_data", fwd_data[127:64], 0);
    tick();
    chk("fwd_hit_one", 64'(fwd_hit), 2'b01);
    chk("fwd_data_one", fwd_data[63:0], 64'd2);
    tick();
    chk("fwd_hit_gone", 64'(fwd_hit), 0);

    // 6: rd=0 entry and skipped lane
    valid = 1'b1;
    bus = {ln(0, 1, 5'd3, 64'h77, 64'h0), ln(1, 1, 5'd0, 64'h55, 64'h900)};
    fwd_raddr = {5'd3, 5'd0};
    tick();
    valid = 1'b0;
    chk("r0_occ", 64'(occupancy), 1);
    chk("r0_cv", 64'(commit_valid), 1);
    chk("r0_we", 64'(rf_we), 0);
    chk("r0_pc", commit_pc, 64'h900);
    chk("r0_fwd", 64'(fwd_hit), 0);
    tick();
    chk("r0_occ_end", 64'(occupancy), 0);

    // 5: two ports, same rd -> younger port wins
    b_valid = 1'b1;
    b_bus = {ln(1, 1, 5'd9, 64'h222, 64'h0), ln(1, 1, 5'd9, 64'h111, 64'h0)};
    b_fwd_raddr = {5'd0, 5'd9};
    tick();
    b_valid = 1'b0;
    chk("wp2_cv", 64'(b_commit_valid), 2'b11);
    chk("wp2_we", 64'(b_rf_we), 2'b10);
    chk("wp2_addr1", 64'(b_rf_waddr[9:5]), 9);
    chk("wp2_data1", b_rf_wdata[127:64], 64'h222);
    chk("wp2_fwd", b_fwd_data[63:0], 64'h222);
    tick();
    chk("wp2_occ_end", 64'(b_occupancy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
